// File: rtl/adpll_lock_ctrl.sv
// ADPLL lock controller: COARSE step/divider search, FINE decimated steering, LOCKED monitoring.
// Optional COARSE residency timeout is compiled in with `define ADPLL_LOCK_TIMEOUT_EN.
module adpll_lock_ctrl #(
  parameter int counterSize = 16,
  parameter int DWELL       = 8,
  parameter int N_REV       = 4,
  parameter int DEC         = 4,
  parameter int LOCK_COUNT  = 64
) (
  input  logic                   clkUD,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pd_up,
  input  logic                   pd_down,
  input  logic [counterSize-1:0] ctrl_word,
  output logic                   up_out,
  output logic                   down_out,
  output logic [1:0]             div_select,
  output logic [1:0]             state,
  output logic                   locked,
  output logic                   lock_lost,
  output logic                   timeout
);

  localparam int DW_W  = $clog2(DWELL + 1);
  localparam int REV_W = $clog2(N_REV + 1);
  localparam int LC_W  = $clog2(LOCK_COUNT + 1);
  localparam int ACC_W = $clog2(DEC + 1) + 1;

  localparam logic [DW_W-1:0]         DW_MAX  = DW_W'(DWELL);
  localparam logic [REV_W-1:0]        REV_MAX = REV_W'(N_REV);
  localparam logic [LC_W-1:0]         LC_MAX  = LC_W'(LOCK_COUNT);
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(DEC);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_COARSE = 2'b01,
    S_FINE   = 2'b10,
    S_LOCKED = 2'b11
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_up, w_up_nxt;
  logic                     r_dn, w_dn_nxt;
  logic [1:0]               r_div, w_div_nxt;
  logic                     r_locked;
  logic                     r_lost, w_lost_nxt;
  logic [DW_W-1:0]          r_dwell, w_dwell_nxt;
  logic [DW_W-1:0]          r_satc, w_satc_nxt;
  logic [REV_W-1:0]         r_rev, w_rev_nxt;
  logic                     r_last_vld, w_last_vld_nxt;
  logic                     r_last_up, w_last_up_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [LC_W-1:0]          r_lock_cnt, w_lock_nxt;
`ifdef ADPLL_LOCK_TIMEOUT_EN
  localparam logic [10:0]   RES_LEN = 11'd1024;
  logic [10:0]              r_res, w_res_nxt;
  logic                     r_tmo, w_tmo_nxt;
`endif

  logic                     w_sat_hi, w_sat_lo, w_sat;
  logic                     w_req_up, w_req_dn;
  logic                     w_acc_up, w_acc_dn;
  logic signed [ACC_W-1:0]  w_acc_inc, w_acc_dec;

  assign w_sat_hi  = &ctrl_word;
  assign w_sat_lo  = ~|ctrl_word;
  assign w_sat     = w_sat_hi | w_sat_lo;
  assign w_req_up  = pd_up & ~pd_down;
  assign w_req_dn  = pd_down & ~pd_up;
  // A step is only accepted when it would not push the counter past its rail.
  assign w_acc_up  = w_req_up & ~w_sat_hi;
  assign w_acc_dn  = w_req_dn & ~w_sat_lo;
  assign w_acc_inc = r_acc + ACC_ONE;
  assign w_acc_dec = r_acc - ACC_ONE;

  always_comb begin
    w_state_nxt    = r_state;
    w_up_nxt       = 1'b0;
    w_dn_nxt       = 1'b0;
    w_div_nxt      = r_div;
    w_lost_nxt     = 1'b0;
    w_dwell_nxt    = r_dwell;
    w_satc_nxt     = '0;
    w_rev_nxt      = r_rev;
    w_last_vld_nxt = r_last_vld;
    w_last_up_nxt  = r_last_up;
    w_acc_nxt      = r_acc;
    w_lock_nxt     = r_lock_cnt;
`ifdef ADPLL_LOCK_TIMEOUT_EN
    w_res_nxt      = '0;
    w_tmo_nxt      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_dwell_nxt    = '0;
        w_rev_nxt      = '0;
        w_last_vld_nxt = 1'b0;
        w_last_up_nxt  = 1'b0;
        w_acc_nxt      = '0;
        w_lock_nxt     = '0;
        if (enable) w_state_nxt = S_COARSE;
      end
      S_COARSE: begin
        w_up_nxt = w_acc_up;
        w_dn_nxt = w_acc_dn;
        if ((r_dwell == DW_MAX) && w_sat_hi && w_req_up) begin
          if (r_div != 2'b00) w_div_nxt = r_div - 2'b01;
          w_dwell_nxt = '0;
        end else if ((r_dwell == DW_MAX) && w_sat_lo && w_req_dn) begin
          if (r_div != 2'b11) w_div_nxt = r_div + 2'b01;
          w_dwell_nxt = '0;
        end else if (r_dwell != DW_MAX) begin
          w_dwell_nxt = r_dwell + DW_W'(1);
        end
        if (w_acc_up || w_acc_dn) begin
          if (r_last_vld && (r_last_up != w_acc_up)) w_rev_nxt = r_rev + REV_W'(1);
          w_last_vld_nxt = 1'b1;
          w_last_up_nxt  = w_acc_up;
        end
        if (w_rev_nxt == REV_MAX) begin
          w_state_nxt    = S_FINE;
          w_acc_nxt      = '0;
          w_lock_nxt     = '0;
          w_rev_nxt      = '0;
          w_last_vld_nxt = 1'b0;
        end
`ifdef ADPLL_LOCK_TIMEOUT_EN
        else begin
          w_res_nxt = r_res + 11'd1;
          // Residency expiry restarts the search from the nominal divider.
          if (w_res_nxt == RES_LEN) begin
            w_div_nxt = 2'b01;
            w_tmo_nxt = 1'b1;
            w_res_nxt = '0;
            w_rev_nxt = '0;
          end
        end
`endif
      end
      S_FINE, S_LOCKED: begin
        if (w_req_up) begin
          if (w_acc_inc == ACC_MAX) begin
            w_up_nxt  = 1'b1;
            w_acc_nxt = '0;
          end else begin
            w_acc_nxt = w_acc_inc;
          end
        end else if (w_req_dn) begin
          if (w_acc_dec == ACC_MIN) begin
            w_dn_nxt  = 1'b1;
            w_acc_nxt = '0;
          end else begin
            w_acc_nxt = w_acc_dec;
          end
        end
        if (r_state == S_FINE) begin
          if (w_sat) begin
            w_lock_nxt = '0;
            w_satc_nxt = r_satc + DW_W'(1);
            if (w_satc_nxt == DW_MAX) begin
              w_state_nxt    = S_COARSE;
              w_rev_nxt      = '0;
              w_last_vld_nxt = 1'b0;
            end
          end else begin
            w_lock_nxt = r_lock_cnt + LC_W'(1);
            if (w_lock_nxt == LC_MAX) w_state_nxt = S_LOCKED;
          end
        end else if (w_sat) begin
          w_state_nxt    = S_COARSE;
          w_lost_nxt     = 1'b1;
          w_rev_nxt      = '0;
          w_last_vld_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_up_nxt    = 1'b0;
      w_dn_nxt    = 1'b0;
      w_div_nxt   = r_div;
      w_lost_nxt  = 1'b0;
`ifdef ADPLL_LOCK_TIMEOUT_EN
      w_tmo_nxt   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clkUD) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_up       <= 1'b0;
      r_dn       <= 1'b0;
      r_div      <= 2'b01;
      r_locked   <= 1'b0;
      r_lost     <= 1'b0;
      r_dwell    <= '0;
      r_satc     <= '0;
      r_rev      <= '0;
      r_last_vld <= 1'b0;
      r_last_up  <= 1'b0;
      r_acc      <= '0;
      r_lock_cnt <= '0;
`ifdef ADPLL_LOCK_TIMEOUT_EN
      r_res      <= '0;
      r_tmo      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_up       <= w_up_nxt;
      r_dn       <= w_dn_nxt;
      r_div      <= w_div_nxt;
      r_locked   <= (w_state_nxt == S_LOCKED);
      r_lost     <= w_lost_nxt;
      r_dwell    <= w_dwell_nxt;
      r_satc     <= w_satc_nxt;
      r_rev      <= w_rev_nxt;
      r_last_vld <= w_last_vld_nxt;
      r_last_up  <= w_last_up_nxt;
      r_acc      <= w_acc_nxt;
      r_lock_cnt <= w_lock_nxt;
`ifdef ADPLL_LOCK_TIMEOUT_EN
      r_res      <= w_res_nxt;
      r_tmo      <= w_tmo_nxt;
`endif
    end
  end

  assign up_out     = r_up;
  assign down_out   = r_dn;
  assign div_select = r_div;
  assign state      = r_state;
  assign locked     = r_locked;
  assign lock_lost  = r_lost;
`ifdef ADPLL_LOCK_TIMEOUT_EN
  assign timeout    = r_tmo;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl; expected values are hand-derived edge by edge.
module tb_adpll_lock_ctrl;

  logic        clkUD = 1'b0;
  logic        reset, enable, pd_up, pd_down;
  logic [15:0] ctrl_word;
  logic        up_out, down_out, locked, lock_lost, timeout;
  logic [1:0]  div_select, state;
  int          n_checks = 0;
  int          n_pass   = 0;

  // {state, up_out, down_out, div_select, locked, lock_lost, timeout}
  logic [8:0] obs;
  assign obs = {state, up_out, down_out, div_select, locked, lock_lost, timeout};

  adpll_lock_ctrl #(
    .counterSize(16), .DWELL(8), .N_REV(4), .DEC(4), .LOCK_COUNT(64)
  ) dut (
    .clkUD(clkUD), .reset(reset), .enable(enable), .pd_up(pd_up), .pd_down(pd_down),
    .ctrl_word(ctrl_word), .up_out(up_out), .down_out(down_out), .div_select(div_select),
    .state(state), .locked(locked), .lock_lost(lock_lost), .timeout(timeout)
  );

  always #5 clkUD = ~clkUD;

  task automatic tick;
    @(posedge clkUD);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; pd_up = 1'b0; pd_down = 1'b0; ctrl_word = 16'h00FF;
    tick();
    reset = 1'b0;
  endtask

  // Leaves the DUT just entered FINE (entered on the last edge), no requests pending.
  task automatic reach_fine;
    do_reset();
    enable = 1'b1; pd_up = 1'b1; pd_down = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      pd_down = (i % 2 == 0); pd_up = !(i % 2 == 0);
      tick();
    end
    pd_up = 1'b0; pd_down = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; pd_up = 1'b1; pd_down = 1'b0; ctrl_word = 16'hFFFF;
    tick();
    n_checks++;
    if (obs !== 9'b00_0_0_01_0_0_0) $display("FAIL reset_state: got %b expected %b", obs, 9'b00_0_0_01_0_0_0);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_coarse_track;
    do_reset();
    enable = 1'b1; pd_up = 1'b1; pd_down = 1'b0; ctrl_word = 16'h00FF;
    tick();
    n_checks++;
    if ({state, up_out} !== 3'b01_0) $display("FAIL track_enter: got %b expected %b", {state, up_out}, 3'b01_0);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({state, up_out, down_out, div_select} !== 6'b01_1_0_01)
        $display("FAIL track_cycle%0d: got %b expected %b", i, {state, up_out, down_out, div_select}, 6'b01_1_0_01);
      else n_pass++;
    end
  endtask

  task automatic test_sat_hi;
    logic [1:0] exp_div;
    do_reset();
    enable = 1'b1; ctrl_word = 16'hFFFF; pd_up = 1'b1; pd_down = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_div = (i >= 10) ? 2'b00 : 2'b01;
      n_checks++;
      if ({state, up_out, down_out, div_select} !== {4'b01_0_0, exp_div})
        $display("FAIL sat_hi_edge%0d: got %b expected %b", i, {state, up_out, down_out, div_select}, {4'b01_0_0, exp_div});
      else n_pass++;
    end
  endtask

  task automatic test_sat_lo;
    logic [1:0] exp_div;
    do_reset();
    enable = 1'b1; ctrl_word = 16'h0000; pd_up = 1'b0; pd_down = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp_div = (i >= 19) ? 2'b11 : ((i >= 10) ? 2'b10 : 2'b01);
      n_checks++;
      if ({state, up_out, down_out, div_select} !== {4'b01_0_0, exp_div})
        $display("FAIL sat_lo_edge%0d: got %b expected %b", i, {state, up_out, down_out, div_select}, {4'b01_0_0, exp_div});
      else n_pass++;
    end
  endtask

  task automatic test_reversal;
    logic d;
    do_reset();
    enable = 1'b1; ctrl_word = 16'h00FF; pd_up = 1'b1; pd_down = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      d = (i % 2 == 0);
      pd_down = d; pd_up = !d;
      tick();
      n_checks++;
      if ({state, up_out, down_out} !== {((i == 4) ? 2'b10 : 2'b01), !d, d})
        $display("FAIL reversal%0d: got %b expected %b", i, {state, up_out, down_out}, {((i == 4) ? 2'b10 : 2'b01), !d, d});
      else n_pass++;
    end
    pd_up = 1'b1; pd_down = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({state, up_out, down_out} !== {2'b10, (i == 4), 1'b0})
        $display("FAIL fine_up%0d: got %b expected %b", i, {state, up_out, down_out}, {2'b10, (i == 4), 1'b0});
      else n_pass++;
    end
    pd_up = 1'b0; pd_down = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({state, up_out, down_out} !== {2'b10, 1'b0, (i == 4)})
        $display("FAIL fine_dn%0d: got %b expected %b", i, {state, up_out, down_out}, {2'b10, 1'b0, (i == 4)});
      else n_pass++;
    end
  endtask

  task automatic test_lock;
    reach_fine();
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) begin
        n_checks++;
        if ({state, locked} !== 3'b10_0) $display("FAIL lock_pre: got %b expected %b", {state, locked}, 3'b10_0);
        else n_pass++;
      end
      if (k == 64) begin
        n_checks++;
        if ({state, locked} !== 3'b11_1) $display("FAIL lock_reach: got %b expected %b", {state, locked}, 3'b11_1);
        else n_pass++;
      end
    end
    ctrl_word = 16'h0000;
    tick();
    n_checks++;
    if ({state, locked, lock_lost} !== 4'b01_0_1) $display("FAIL lock_lost: got %b expected %b", {state, locked, lock_lost}, 4'b01_0_1);
    else n_pass++;
    tick();
    n_checks++;
    if ({state, locked, lock_lost} !== 4'b01_0_0) $display("FAIL lost_pulse_end: got %b expected %b", {state, locked, lock_lost}, 4'b01_0_0);
    else n_pass++;
  endtask

  task automatic test_fine_sat;
    reach_fine();
    ctrl_word = 16'hFFFF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k >= 7) begin
        n_checks++;
        if ({state, lock_lost} !== {((k == 8) ? 2'b01 : 2'b10), 1'b0})
          $display("FAIL fine_sat%0d: got %b expected %b", k, {state, lock_lost}, {((k == 8) ? 2'b01 : 2'b10), 1'b0});
        else n_pass++;
      end
    end
  endtask

  task automatic test_both_req_and_enable;
    do_reset();
    enable = 1'b1; pd_up = 1'b1; pd_down = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({state, up_out, down_out} !== 4'b01_0_0) $display("FAIL both_coarse%0d: got %b expected %b", i, {state, up_out, down_out}, 4'b01_0_0);
      else n_pass++;
    end
    reach_fine();
    pd_up = 1'b1; pd_down = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      tick();
      n_checks++;
      if ({state, up_out, down_out} !== {((k >= 64) ? 2'b11 : 2'b10), 2'b00})
        $display("FAIL both_fine%0d: got %b expected %b", k, {state, up_out, down_out}, {((k >= 64) ? 2'b11 : 2'b10), 2'b00});
      else n_pass++;
    end
    enable = 1'b0;
    tick();
    n_checks++;
    if ({state, up_out, down_out, div_select, locked} !== 7'b00_0_0_01_0)
      $display("FAIL enable_drop: got %b expected %b", {state, up_out, down_out, div_select, locked}, 7'b00_0_0_01_0);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    reach_fine();
    pd_up = 1'b1; pd_down = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (obs !== 9'b00_0_0_01_0_0_0) $display("FAIL reset_mid: got %b expected %b", obs, 9'b00_0_0_01_0_0_0);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if ({state, up_out} !== 3'b01_0) $display("FAIL reset_resume: got %b expected %b", {state, up_out}, 3'b01_0);
    else n_pass++;
    tick();
    n_checks++;
    if ({state, up_out} !== 3'b01_1) $display("FAIL reset_resume_up: got %b expected %b", {state, up_out}, 3'b01_1);
    else n_pass++;
  endtask

`ifdef ADPLL_LOCK_TIMEOUT_EN
  task automatic test_timeout;
    int         hit;
    logic [1:0] div_at_hit;
    hit = 0; div_at_hit = 2'b00;
    do_reset();
    enable = 1'b1; ctrl_word = 16'hFFFF; pd_up = 1'b1; pd_down = 1'b0;
    tick();
    for (int c = 1; c <= 1100; c++) begin
      tick();
      if (timeout && hit == 0) begin
        hit = c;
        div_at_hit = div_select;
      end
    end
    n_checks++;
    if (hit != 1024) $display("FAIL timeout_cycle: got %0d expected %0d", hit, 1024);
    else n_pass++;
    n_checks++;
    if (div_at_hit !== 2'b01) $display("FAIL timeout_div: got %b expected %b", div_at_hit, 2'b01);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_coarse_track();
    test_sat_hi();
    test_sat_lo();
    test_reversal();
    test_lock();
    test_fine_sat();
    test_both_req_and_enable();
    test_reset_mid();
`ifdef ADPLL_LOCK_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
